// File: rtl/reg_bus_initiator.sv
// Single-outstanding register bus initiator: turns valid/ready commands into one
// reg_cs access at a time, guarded by an ack timeout, and returns a valid/ready response.
module reg_bus_initiator #(
    parameter int AW      = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic          mclk,
    input  logic          h_reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    input  logic [3:0]    cmd_be,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          reg_cs,
    output logic          reg_wr,
    output logic [AW-1:0] reg_addr,
    output logic [31:0]   reg_wdata,
    output logic [3:0]    reg_be,
    input  logic [31:0]   reg_rdata,
    input  logic          reg_ack,
    output logic          busy
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            reg_cs    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_be    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        reg_cs    <= 1'b1;
                        reg_wr    <= cmd_wr;
                        reg_addr  <= cmd_addr;
                        reg_wdata <= cmd_wdata;
                        reg_be    <= cmd_be;
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Ack is checked first so an ack on the final allowed cycle still wins.
                    if (reg_ack) begin
                        reg_cs    <= 1'b0;
                        rsp_rdata <= reg_wr ? '0 : reg_rdata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        reg_cs    <= 1'b0;
                        rsp_rdata <= 32'hFFFF_FFFF;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Returning through IDLE keeps reg_cs low for at least two cycles.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
